// File: rtl/ts_null_stuffer_if.sv
`default_nettype none
// ============================================================================
// Interface : ts_null_stuffer_if
// Desc      : Byte-stream bus into and out of the constant-rate TS stuffer.
// Revision  : 1.0 - initial release
// ============================================================================
interface ts_null_stuffer_if;
    logic [7:0]  DATA_IN;
    logic        D_VALID_IN;
    logic        P_SYNC_IN;
    logic [7:0]  DATA_OUT;
    logic        D_VALID_OUT;
    logic        P_SYNC_OUT;
    logic        SYNC_ERR;
    logic        OVERFLOW;
    logic        NULL_INS;
`ifdef STUFF_STATS_EN
    logic [15:0] NULL_CNT;
    logic [15:0] DROP_CNT;
    logic [15:0] SERR_CNT;

    modport master (
        output DATA_IN, D_VALID_IN, P_SYNC_IN,
        input  DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR, OVERFLOW, NULL_INS,
        input  NULL_CNT, DROP_CNT, SERR_CNT
    );
    modport slave (
        input  DATA_IN, D_VALID_IN, P_SYNC_IN,
        output DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR, OVERFLOW, NULL_INS,
        output NULL_CNT, DROP_CNT, SERR_CNT
    );
`else
    modport master (
        output DATA_IN, D_VALID_IN, P_SYNC_IN,
        input  DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR, OVERFLOW, NULL_INS
    );
    modport slave (
        input  DATA_IN, D_VALID_IN, P_SYNC_IN,
        output DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR, OVERFLOW, NULL_INS
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ts_null_stuffer.sv
`default_nettype none
// ============================================================================
// Module   : ts_null_stuffer
// Desc     : Two-slot TS packet buffer, constant-rate playout with null stuffing.
//            Define STUFF_STATS_EN for NULL/DROP/SERR event counters.
// Revision : 1.0 - initial release
// ============================================================================
module ts_null_stuffer #(
    parameter int OUT_DIV = 1,
    parameter int PKT_LEN = 188
) (
    input  wire logic         SYS_CLK,
    input  wire logic         RST,
    ts_null_stuffer_if.slave  bus
);
    localparam logic [7:0] c_div_max = 8'(OUT_DIV - 1);
    localparam logic [7:0] c_last    = 8'(PKT_LEN - 1);

    localparam logic [1:0] W_HUNT = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;
    localparam logic [0:0] R_NULL = 1'b0;
    localparam logic [0:0] R_PKT  = 1'b1;

    logic [7:0] r_mem [0:511];
    logic [7:0] r_div;
    logic [1:0] r_wstate;
    logic [7:0] r_widx;
    logic       r_wptr;
    logic [1:0] r_full;
    logic       r_rptr;
    logic [0:0] r_rmode;
    logic [7:0] r_ridx;
    logic [7:0] r_data_out;
    logic       r_dvalid, r_psync, r_serr, r_ovf, r_null_ins;

    logic       w_sync, w_start, w_tick, w_first, w_release;
    logic [1:0] w_wstate_n;
    logic [7:0] w_widx_n, w_waddr_idx, w_null_byte, w_rbyte;
    logic       w_we, w_commit, w_serr, w_ovf;
    logic [0:0] w_rmode_n;
    logic [1:0] w_set, w_clr;

    assign w_sync  = bus.D_VALID_IN & bus.P_SYNC_IN;
    assign w_start = w_sync & (bus.DATA_IN == 8'h47);

    always_comb begin
        w_wstate_n  = r_wstate;
        w_widx_n    = r_widx;
        w_waddr_idx = r_widx;
        w_we        = 1'b0;
        w_commit    = 1'b0;
        w_serr      = 1'b0;
        w_ovf       = 1'b0;
        case (r_wstate)
            W_FILL: begin
                if (w_sync) begin
                    // A sync beat mid-packet abandons it; a real 0x47 reuses the slot.
                    w_serr = 1'b1;
                    if (w_start) begin
                        w_we        = 1'b1;
                        w_waddr_idx = 8'd0;
                        w_widx_n    = 8'd1;
                    end else begin
                        w_wstate_n = W_HUNT;
                    end
                end else if (bus.D_VALID_IN) begin
                    w_we = 1'b1;
                    if (r_widx == c_last) begin
                        w_commit   = 1'b1;
                        w_widx_n   = 8'd0;
                        w_wstate_n = W_HUNT;
                    end else begin
                        w_widx_n = r_widx + 8'd1;
                    end
                end
            end
            default: begin
                if (w_start) begin
                    if (!r_full[r_wptr]) begin
                        w_we        = 1'b1;
                        w_waddr_idx = 8'd0;
                        w_widx_n    = 8'd1;
                        w_wstate_n  = W_FILL;
                    end else begin
                        w_ovf      = 1'b1;
                        w_wstate_n = W_DROP;
                    end
                end
            end
        endcase
    end

    assign w_tick    = (r_div == 8'd0);
    assign w_first   = (r_ridx == 8'd0);
    assign w_rmode_n = w_first ? (r_full[r_rptr] ? R_PKT : R_NULL) : r_rmode;
    assign w_release = w_tick & (r_ridx == c_last) & (r_rmode == R_PKT);

    always_comb begin
        case (r_ridx)
            8'd0:    w_null_byte = 8'h47;
            8'd1:    w_null_byte = 8'h1F;
            8'd3:    w_null_byte = 8'h10;
            default: w_null_byte = 8'hFF;
        endcase
    end

    assign w_rbyte = (w_rmode_n == R_PKT) ? r_mem[{r_rptr, r_ridx}] : w_null_byte;
    assign w_set   = {w_commit & r_wptr, w_commit & ~r_wptr};
    assign w_clr   = {w_release & r_rptr, w_release & ~r_rptr};

    always_ff @(posedge SYS_CLK) begin
        if (w_we && !RST) begin
            r_mem[{r_wptr, w_waddr_idx}] <= bus.DATA_IN;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_div      <= 8'd0;
            r_wstate   <= W_HUNT;
            r_widx     <= 8'd0;
            r_wptr     <= 1'b0;
            r_full     <= 2'b00;
            r_rptr     <= 1'b0;
            r_rmode    <= R_NULL;
            r_ridx     <= 8'd0;
            r_data_out <= 8'd0;
            r_dvalid   <= 1'b0;
            r_psync    <= 1'b0;
            r_serr     <= 1'b0;
            r_ovf      <= 1'b0;
            r_null_ins <= 1'b0;
        end else begin
            r_div    <= (r_div == c_div_max) ? 8'd0 : r_div + 8'd1;
            r_wstate <= w_wstate_n;
            r_widx   <= w_widx_n;
            if (w_commit) begin
                r_wptr <= ~r_wptr;
            end
            // Commit and release always target different slots, so both apply.
            r_full     <= (r_full & ~w_clr) | w_set;
            r_dvalid   <= w_tick;
            r_psync    <= w_tick & w_first;
            r_null_ins <= w_tick & w_first & ~r_full[r_rptr];
            r_serr     <= w_serr;
            r_ovf      <= w_ovf;
            if (w_tick) begin
                r_data_out <= w_rbyte;
                r_rmode    <= w_rmode_n;
                if (r_ridx == c_last) begin
                    r_ridx <= 8'd0;
                    if (r_rmode == R_PKT) begin
                        r_rptr <= ~r_rptr;
                    end
                end else begin
                    r_ridx <= r_ridx + 8'd1;
                end
            end
        end
    end

    assign bus.DATA_OUT    = r_data_out;
    assign bus.D_VALID_OUT = r_dvalid;
    assign bus.P_SYNC_OUT  = r_psync;
    assign bus.SYNC_ERR    = r_serr;
    assign bus.OVERFLOW    = r_ovf;
    assign bus.NULL_INS    = r_null_ins;

`ifdef STUFF_STATS_EN
    logic [15:0] r_null_cnt, r_drop_cnt, r_serr_cnt;

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_null_cnt <= 16'd0;
            r_drop_cnt <= 16'd0;
            r_serr_cnt <= 16'd0;
        end else begin
            if (r_null_ins && r_null_cnt != 16'hFFFF) r_null_cnt <= r_null_cnt + 16'd1;
            if (r_ovf && r_drop_cnt != 16'hFFFF)      r_drop_cnt <= r_drop_cnt + 16'd1;
            if (r_serr && r_serr_cnt != 16'hFFFF)     r_serr_cnt <= r_serr_cnt + 16'd1;
        end
    end

    assign bus.NULL_CNT = r_null_cnt;
    assign bus.DROP_CNT = r_drop_cnt;
    assign bus.SERR_CNT = r_serr_cnt;
`endif
endmodule
`default_nettype wire
